// File: rtl/ej32_pkg.sv
// Shared types for the eJ32 instruction fetch unit: FSM state encoding and
// the prefetch queue entry layout.
package ej32_pkg;

  localparam int EJ32_ASZ = 17;

  typedef enum logic [1:0] {
    sRUN   = 2'd0,
    sFULL  = 2'd1,
    sFLUSH = 2'd2
  } fetch_state;

  typedef struct packed {
    logic [7:0]          code;
    logic [EJ32_ASZ-1:0] addr;
  } q_entry_t;

endpackage

// File: rtl/ej32_fetch_if.sv
// Fetch-unit bus bundle: branch redirect, program memory read port and
// decoder-facing byte stream. master = fetch unit, slave = its surroundings.
interface ej32_fetch_if #(
  parameter int ASZ = 17
);
  logic [ASZ-1:0] br_p;
  logic           br_psel;
  logic           mem_req;
  logic [ASZ-1:0] mem_a;
  logic [7:0]     mem_d;
  logic [7:0]     code_o;
  logic [ASZ-1:0] p_o;
  logic           code_vld;
  logic           code_rdy;

  modport master (
    input  br_p, br_psel, mem_d, code_rdy,
    output mem_req, mem_a, code_o, p_o, code_vld
  );

  modport slave (
    output br_p, br_psel, mem_d, code_rdy,
    input  mem_req, mem_a, code_o, p_o, code_vld
  );
endinterface

// File: rtl/ej32_fetch_q.sv
// Prefetch queue: DEPTH-entry circular FIFO of {byte, addr}.
// Clear outranks push and pop; callers never push when full or pop when empty.
module ej32_fetch_q
  import ej32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  q_entry_t                   push_e,
  output q_entry_t                   head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  q_entry_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_e;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/ej32_fetch.sv
// eJ32 instruction fetch with prefetch queue and branch redirect flush.
// Optional redirect counter port perf_flush under EJ32_FETCH_PERF_EN.
//
// state  | meaning
// sRUN   | issuing sequential reads while queue + in-flight < DEPTH
// sFULL  | queue plus in-flight read fill DEPTH; waiting for a pop
// sFLUSH | bubble cycle after a redirect; no request issued
module ej32_fetch
  import ej32_pkg::*;
#(
  parameter int ASZ   = EJ32_ASZ,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  ej32_fetch_if.master bus
`ifdef EJ32_FETCH_PERF_EN
  ,
  output logic [15:0]  perf_flush
`endif
);
  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state      state;
  logic [ASZ-1:0]  pc;
  logic [ASZ-1:0]  pc_issued;
  logic            pend;
  logic [CW-1:0]   count;
  logic            req;
  logic            push;
  logic            pop;
  logic            room;
  logic            room_next;
  logic [CW:0]     occ;
  logic [CW:0]     occ_next;
  q_entry_t        push_e;
  q_entry_t        head;

  // In-flight read reserves a slot so its response always has room.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, pend};
  assign room      = occ < DEPTH_W;
  assign req       = !rst && (state != sFLUSH) && room && !bus.br_psel;
  assign pop       = (count != '0) && bus.code_rdy && !bus.br_psel;
  assign push      = pend && !bus.br_psel;
  assign occ_next  = {1'b0, count} + {{CW{1'b0}}, push} + {{CW{1'b0}}, req}
                   - {{CW{1'b0}}, pop};
  assign room_next = occ_next < DEPTH_W;

  assign push_e.code = bus.mem_d;
  assign push_e.addr = EJ32_ASZ'(pc_issued);

  ej32_fetch_q #(
    .DEPTH (DEPTH)
  ) u_q (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.br_psel),
    .push   (push),
    .pop    (pop),
    .push_e (push_e),
    .head   (head),
    .count  (count)
  );

  assign bus.mem_req  = req;
  assign bus.mem_a    = pc;
  assign bus.code_o   = head.code;
  assign bus.p_o      = ASZ'(head.addr);
  assign bus.code_vld = count != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= sRUN;
      pc        <= '0;
      pc_issued <= '0;
      pend      <= 1'b0;
    end else if (bus.br_psel) begin
      state <= sFLUSH;
      pc    <= bus.br_p;
      pend  <= 1'b0;
    end else begin
      pend <= req;
      if (req) begin
        pc        <= pc + 1'b1;
        pc_issued <= pc;
      end
      case (state)
        sFLUSH:  state <= sRUN;
        default: state <= room_next ? sRUN : sFULL;
      endcase
    end
  end

`ifdef EJ32_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_flush <= '0;
    end else if (bus.br_psel && (perf_flush != 16'hFFFF)) begin
      perf_flush <= perf_flush + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ej32_fetch.sv
// Directed bench for ej32_fetch: memory model, expected-byte scoreboard and
// cycle-exact checks of cold start, backpressure, redirect and wrap.
module tb_ej32_fetch;
  import ej32_pkg::*;

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   nreq;
  exp_t exp_q[$];
  exp_t sb_e;
`ifdef EJ32_FETCH_PERF_EN
  logic [15:0] perf_flush;
`endif

  ej32_fetch_if #(.ASZ(17)) bus ();

  ej32_fetch #(
    .ASZ   (17),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef EJ32_FETCH_PERF_EN
    ,
    .perf_flush (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mbyte(logic [16:0] a);
    if (a < 17'd3) return 8'h10 * (8'(a) + 8'd1);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5A;
  endfunction

  // Program memory: data returned exactly one cycle after the request.
  always @(posedge clk) begin
    bus.mem_d <= bus.mem_req ? mbyte(bus.mem_a) : 8'hEE;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_stream(logic [16:0] base, int n);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      e.a = base + 17'(i);
      e.d = mbyte(e.a);
      exp_q.push_back(e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Every byte the decoder accepts must be the next one of the current stream.
  always @(negedge clk) begin
    if (!rst && bus.code_vld && bus.code_rdy && !bus.br_psel && exp_q.size() != 0) begin
      sb_e = exp_q.pop_front();
      chk("sb_addr", 32'(bus.p_o), 32'(sb_e.a));
      chk("sb_byte", 32'(bus.code_o), 32'(sb_e.d));
    end
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.br_psel  = 1'b0;
    bus.br_p     = '0;
    bus.code_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_code_vld", 32'(bus.code_vld), 0);
    chk("rst_code_o", 32'(bus.code_o), 0);
    chk("rst_p_o", 32'(bus.p_o), 0);
`ifdef EJ32_FETCH_PERF_EN
    chk("rst_perf", 32'(perf_flush), 0);
`endif

    // cold start
    nxt(); rst = 1'b0; start_stream(17'h0, 64);
    @(negedge clk);
    chk("cold_req", 32'(bus.mem_req), 1);
    chk("cold_a", 32'(bus.mem_a), 0);
    chk("cold_vld0", 32'(bus.code_vld), 0);
    nxt(); @(negedge clk);
    chk("c1_vld", 32'(bus.code_vld), 0);
    chk("c1_a", 32'(bus.mem_a), 1);
    nxt(); @(negedge clk);
    chk("c2_vld", 32'(bus.code_vld), 1);
    chk("c2_code", 32'(bus.code_o), 32'h10);
    chk("c2_p", 32'(bus.p_o), 0);
    nxt(); @(negedge clk);
    chk("c3_code", 32'(bus.code_o), 32'h20);
    chk("c3_p", 32'(bus.p_o), 1);
    nxt(); @(negedge clk);
    chk("c4_code", 32'(bus.code_o), 32'h30);
    chk("c4_p", 32'(bus.p_o), 2);

    // backpressure from an empty queue
    nxt(); bus.code_rdy = 1'b0; bus.br_psel = 1'b1; bus.br_p = 17'h40;
    start_stream(17'h40, 64);
    nxt(); bus.br_psel = 1'b0; nreq = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_req) nreq++;
      nxt();
    end
    @(negedge clk);
    chk("bp_nreq", 32'(nreq), 4);
    chk("bp_count", 32'(dut.count), 4);
    chk("bp_state", 32'(dut.state), 32'(sFULL));
    chk("bp_req", 32'(bus.mem_req), 0);
    chk("bp_vld", 32'(bus.code_vld), 1);
    nxt(); bus.code_rdy = 1'b1; nreq = 0;
    @(negedge clk);
    if (bus.mem_req) nreq++;
    for (int i = 0; i < 6; i++) begin
      nxt(); bus.code_rdy = 1'b0;
      @(negedge clk);
      if (bus.mem_req) nreq++;
    end
    chk("bp_one_req", 32'(nreq), 1);

    // redirect with 3 queued bytes and one read in flight
    nxt(); bus.code_rdy = 1'b1;
    nxt(); bus.code_rdy = 1'b0;
    nxt(); bus.br_psel = 1'b1; bus.br_p = 17'h00123;
    start_stream(17'h00123, 64);
    @(negedge clk);
    chk("rd_pre_cnt", 32'(dut.count), 3);
    chk("rd_pre_pend", 32'(dut.pend), 1);
    chk("rd_n_req", 32'(bus.mem_req), 0);
    nxt(); bus.br_psel = 1'b0;
    @(negedge clk);
    chk("rd_n1_vld", 32'(bus.code_vld), 0);
    chk("rd_n1_req", 32'(bus.mem_req), 0);
    chk("rd_n1_state", 32'(dut.state), 32'(sFLUSH));
    nxt(); @(negedge clk);
    chk("rd_n2_req", 32'(bus.mem_req), 1);
    chk("rd_n2_a", 32'(bus.mem_a), 32'h123);
    nxt(); @(negedge clk);
    chk("rd_n3_vld", 32'(bus.code_vld), 0);
    nxt(); bus.code_rdy = 1'b1;
    @(negedge clk);
    chk("rd_n4_vld", 32'(bus.code_vld), 1);
    chk("rd_n4_p", 32'(bus.p_o), 32'h123);
    chk("rd_n4_code", 32'(bus.code_o), 32'(mbyte(17'h123)));
    repeat (4) nxt();

    // redirect while the decoder pops in the same cycle
    bus.br_psel = 1'b1; bus.br_p = 17'h00200;
    start_stream(17'h00200, 64);
    @(negedge clk);
    chk("sp_pre_vld", 32'(bus.code_vld), 1);
    nxt(); bus.br_psel = 1'b0;
    @(negedge clk);
    chk("sp_n1_vld", 32'(bus.code_vld), 0);
    chk("sp_n1_cnt", 32'(dut.count), 0);
    nxt(); nxt(); nxt();
    @(negedge clk);
    chk("sp_n4_p", 32'(bus.p_o), 32'h200);
    chk("sp_n4_code", 32'(bus.code_o), 32'(mbyte(17'h200)));
    repeat (3) nxt();

    // address wrap at the top of the 128K space
    bus.br_psel = 1'b1; bus.br_p = 17'h1FFFF;
    start_stream(17'h1FFFF, 64);
    nxt(); bus.br_psel = 1'b0;
    nxt(); nxt(); nxt();
    @(negedge clk);
    chk("wr_p0", 32'(bus.p_o), 32'h1FFFF);
    chk("wr_c0", 32'(bus.code_o), 32'(mbyte(17'h1FFFF)));
    nxt(); @(negedge clk);
    chk("wr_p1", 32'(bus.p_o), 0);
    chk("wr_c1", 32'(bus.code_o), 32'h10);
`ifdef EJ32_FETCH_PERF_EN
    chk("perf_four", 32'(perf_flush), 4);
`endif
    repeat (3) nxt();

    // reset in the middle of streaming
    rst = 1'b1;
    @(negedge clk);
    chk("mr_req", 32'(bus.mem_req), 0);
    nxt(); @(negedge clk);
    chk("mr_vld", 32'(bus.code_vld), 0);
    chk("mr_p", 32'(bus.p_o), 0);
    chk("mr_code", 32'(bus.code_o), 0);
    chk("mr_pend", 32'(dut.pend), 0);
    chk("mr_state", 32'(dut.state), 32'(sRUN));
`ifdef EJ32_FETCH_PERF_EN
    chk("mr_perf", 32'(perf_flush), 0);
`endif
    nxt(); rst = 1'b0; start_stream(17'h0, 64);
    @(negedge clk);
    chk("mr_cold_req", 32'(bus.mem_req), 1);
    chk("mr_cold_a", 32'(bus.mem_a), 0);
    nxt(); nxt();
    @(negedge clk);
    chk("mr_c2_vld", 32'(bus.code_vld), 1);
    chk("mr_c2_code", 32'(bus.code_o), 32'h10);

`ifdef EJ32_FETCH_PERF_EN
    for (int k = 0; k < 3; k++) begin
      nxt(); bus.br_psel = 1'b1; bus.br_p = 17'h300 + 17'(k * 16);
      start_stream(17'h300 + 17'(k * 16), 64);
      nxt(); bus.br_psel = 1'b0;
      nxt();
    end
    @(negedge clk);
    chk("perf_three", 32'(perf_flush), 3);
    nxt(); rst = 1'b1;
    nxt(); @(negedge clk);
    chk("perf_rst", 32'(perf_flush), 0);
    nxt(); rst = 1'b0;
`endif

    repeat (3) nxt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
